// File: rtl/cpu6502_bus_responder_if.sv
// ---------------------------------------------------------------------------
// cpu6502_bus_responder_if
//   Bundles the cpu6502 external bus, the preload port and the write-log
//   drain port seen by cpu6502_bus_responder.
//
//   master : CPU / bench side (drives addr, wdata, rw, clk2, ld_*, log_pop)
//   slave  : responder side   (drives rdata, log_*, write_count)
//
//   addr        16  CPU address bus
//   wdata        8  CPU write data
//   rw           1  1 = read, 0 = write
//   clk2         1  CPU phi2 phase
//   rdata        8  registered read data back to the CPU
//   ld_en        1  preload strobe
//   ld_addr     16  preload address
//   ld_data      8  preload data
//   log_valid    1  write log non-empty
//   log_addr    16  head entry address (0 when empty)
//   log_data     8  head entry data (0 when empty)
//   log_pop      1  pop head entry
//   log_overflow 1  sticky dropped-entry flag
//   write_count 16  saturating committed-write counter
// ---------------------------------------------------------------------------
interface cpu6502_bus_responder_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rw;
    logic        clk2;
    logic [7:0]  rdata;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        log_valid;
    logic [15:0] log_addr;
    logic [7:0]  log_data;
    logic        log_pop;
    logic        log_overflow;
    logic [15:0] write_count;

    modport master (
        output addr, wdata, rw, clk2, ld_en, ld_addr, ld_data, log_pop,
        input  rdata, log_valid, log_addr, log_data, log_overflow, write_count
    );

    modport slave (
        input  addr, wdata, rw, clk2, ld_en, ld_addr, ld_data, log_pop,
        output rdata, log_valid, log_addr, log_data, log_overflow, write_count
    );
endinterface

// File: rtl/cpu6502_bus_responder.sv
// ---------------------------------------------------------------------------
// cpu6502_bus_responder
//   Memory-side responder for the cpu6502 external bus. Answers reads from an
//   internal RAM (or the reset vector / fill value), commits CPU writes on the
//   falling edge of phi2, and logs every committed write into a FIFO so the
//   stores can be drained and checked in order.
//
//   Parameters
//     RAM_AW     RAM address width; RAM spans 0 .. 2**RAM_AW-1 (not mirrored)
//     LOG_DEPTH  write-log entries (power of two, >= 2)
//     RESET_VEC  returned at 0xFFFC (low byte) / 0xFFFD (high byte)
//     FILL       read data for unmapped addresses and rdata reset value
//
//   Ports
//     clk    in  system clock (same clock as the CPU)
//     reset  in  synchronous active-high reset; RAM contents are kept
//     bus    slave modport of cpu6502_bus_responder_if
// ---------------------------------------------------------------------------
module cpu6502_bus_responder #(
    parameter int          RAM_AW    = 11,
    parameter int          LOG_DEPTH = 8,
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter logic [7:0]  FILL      = 8'hff
) (
    input  logic                     clk,
    input  logic                     reset,
    cpu6502_bus_responder_if.slave   bus
);

    localparam int RAM_WORDS = 1 << RAM_AW;
    localparam int LPW       = $clog2(LOG_DEPTH);

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic              cpu_hit;
    logic              ld_hit;
    logic [RAM_AW-1:0] cpu_idx;
    logic [RAM_AW-1:0] ld_idx;

    assign cpu_hit = ((bus.addr    >> RAM_AW) == 16'd0);
    assign ld_hit  = ((bus.ld_addr >> RAM_AW) == 16'd0) && bus.ld_en;
    assign cpu_idx = bus.addr[RAM_AW-1:0];
    assign ld_idx  = bus.ld_addr[RAM_AW-1:0];

    // -----------------------------------------------------------------------
    // phi2 falling-edge detect. clk2_q resets to 0 so the first cycle after
    // reset can never look like a falling edge. Reset also masks the commit
    // of a phi2 cycle that is in progress while reset is held.
    // -----------------------------------------------------------------------
    logic clk2_q;
    logic commit;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk2_q <= 1'b0;
        end else begin
            clk2_q <= bus.clk2;
        end
    end

    assign commit = clk2_q && !bus.clk2 && !bus.rw && !reset;

    // -----------------------------------------------------------------------
    // RAM: single write port shared by preload and CPU commit. Preload wins
    // when both want the port; the commit is still logged and counted below.
    // -----------------------------------------------------------------------
    logic [7:0]        ram [RAM_WORDS];
    logic [7:0]        ram_rd_q;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_wa;
    logic [7:0]        ram_wd;

    always_comb begin
        ram_we = 1'b0;
        ram_wa = cpu_idx;
        ram_wd = bus.wdata;
        if (ld_hit) begin
            ram_we = 1'b1;
            ram_wa = ld_idx;
            ram_wd = bus.ld_data;
        end else if (commit && cpu_hit) begin
            ram_we = 1'b1;
        end
    end

    // Read-before-write: a read in the commit cycle sees the old contents.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_wa] <= ram_wd;
        end
        ram_rd_q <= ram[cpu_idx];
    end

    // -----------------------------------------------------------------------
    // Read mux select, registered alongside the RAM read so rdata always
    // reflects the address presented one clock earlier.
    // -----------------------------------------------------------------------
    logic       sel_ram_q;
    logic [7:0] const_q;
    logic [7:0] const_d;

    always_comb begin
        const_d = FILL;
        if (bus.addr == 16'hfffc) begin
            const_d = RESET_VEC[7:0];
        end else if (bus.addr == 16'hfffd) begin
            const_d = RESET_VEC[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_ram_q <= 1'b0;
            const_q   <= FILL;
        end else begin
            sel_ram_q <= cpu_hit;
            const_q   <= const_d;
        end
    end

    assign bus.rdata = sel_ram_q ? ram_rd_q : const_q;

    // -----------------------------------------------------------------------
    // Write-log FIFO. Pointers carry an extra wrap bit: equal pointers mean
    // empty, pointers differing only in the wrap bit mean full.
    // -----------------------------------------------------------------------
    logic [LPW:0]   wr_ptr_q, wr_ptr_d;
    logic [LPW:0]   rd_ptr_q, rd_ptr_d;
    logic [LPW-1:0] wr_idx;
    logic [LPW-1:0] rd_idx;
    logic           fifo_empty;
    logic           fifo_full;
    logic           pop;
    logic           push_ok;
    logic           overflow_q, overflow_d;
    logic [15:0]    count_q, count_d;

    assign wr_idx     = wr_ptr_q[LPW-1:0];
    assign rd_idx     = rd_ptr_q[LPW-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_idx == rd_idx) && (wr_ptr_q[LPW] != rd_ptr_q[LPW]);
    assign pop        = bus.log_pop && !fifo_empty;
    // A push into a full FIFO is accepted only if the head leaves this cycle;
    // the new entry then lands in the slot being vacated.
    assign push_ok    = commit && (!fifo_full || pop);

    // Storage: one register per entry, each with its own write enable.
    logic [23:0] ent_vec [LOG_DEPTH];

    for (genvar gi = 0; gi < LOG_DEPTH; gi++) begin : g_ent
        logic [23:0] ent_q;

        always_ff @(posedge clk) begin
            if (push_ok && (wr_idx == LPW'(gi))) begin
                ent_q <= {bus.addr, bus.wdata};
            end
        end

        assign ent_vec[gi] = ent_q;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        count_d    = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (commit && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (commit && (count_q != 16'hffff)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

    logic [23:0] head;
    assign head = ent_vec[rd_idx];

    assign bus.log_valid    = !fifo_empty;
    assign bus.log_addr     = fifo_empty ? 16'd0 : head[23:8];
    assign bus.log_data     = fifo_empty ? 8'd0  : head[7:0];
    assign bus.log_overflow = overflow_q;
    assign bus.write_count  = count_q;

endmodule

// File: tb/tb_cpu6502_bus_responder.sv
module tb_cpu6502_bus_responder;

    logic clk;
    logic reset;
    int   vec_cnt;
    int   err_cnt;

    cpu6502_bus_responder_if bus ();

    cpu6502_bus_responder #(
        .RAM_AW    (11),
        .LOG_DEPTH (8),
        .RESET_VEC (16'h1234),
        .FILL      (8'hff)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        tick();
        bus.ld_en   = 1'b0;
        $display("txn preload addr=%h data=%h", a, d);
    endtask

    task automatic cpu_read(input logic [15:0] a);
        bus.addr = a;
        bus.rw   = 1'b1;
        tick();
        $display("txn read  addr=%h rdata=%h", a, bus.rdata);
    endtask

    // Full phi2 write cycle; rd_commit is rdata sampled right after the
    // commit edge, optional log_pop coincides with the commit edge.
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d,
                             input logic do_pop, output logic [7:0] rd_commit);
        bus.addr  = a;
        bus.wdata = d;
        bus.rw    = 1'b0;
        bus.clk2  = 1'b1;
        tick();
        bus.clk2    = 1'b0;
        bus.log_pop = do_pop;
        tick();
        rd_commit   = bus.rdata;
        bus.log_pop = 1'b0;
        bus.rw      = 1'b1;
        tick();
        $display("txn write addr=%h data=%h pop=%0d", a, d, do_pop);
    endtask

    task automatic pop_one();
        bus.log_pop = 1'b1;
        tick();
        bus.log_pop = 1'b0;
        $display("txn pop");
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick();
        preload(16'h0080, 8'hc0);
        preload(16'h0099, 8'h00);
        preload(16'h0400, 8'h11);
        tick();
        vec_cnt++; if (bus.rdata !== 8'hff) begin err_cnt++; $display("FAIL reset_rdata got=%h exp=ff", bus.rdata); end
        vec_cnt++; if (bus.log_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got=%b exp=0", bus.log_valid); end
        vec_cnt++; if (bus.log_overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_ovf got=%b exp=0", bus.log_overflow); end
        vec_cnt++; if (bus.write_count !== 16'd0) begin err_cnt++; $display("FAIL reset_count got=%h exp=0000", bus.write_count); end
        vec_cnt++; if (bus.log_addr !== 16'd0) begin err_cnt++; $display("FAIL reset_log_addr got=%h exp=0000", bus.log_addr); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_sta();
        logic [7:0] rc;
        cpu_read(16'h0080);
        vec_cnt++; if (bus.rdata !== 8'hc0) begin err_cnt++; $display("FAIL sta_read80 got=%h exp=c0", bus.rdata); end
        cpu_write(16'h0099, 8'hc0, 1'b0, rc);
        vec_cnt++; if (rc !== 8'h00) begin err_cnt++; $display("FAIL sta_old_data got=%h exp=00", rc); end
        vec_cnt++; if (bus.rdata !== 8'hc0) begin err_cnt++; $display("FAIL sta_new_data got=%h exp=c0", bus.rdata); end
        vec_cnt++; if (bus.log_valid !== 1'b1) begin err_cnt++; $display("FAIL sta_valid got=%b exp=1", bus.log_valid); end
        vec_cnt++; if (bus.log_addr !== 16'h0099) begin err_cnt++; $display("FAIL sta_log_addr got=%h exp=0099", bus.log_addr); end
        vec_cnt++; if (bus.log_data !== 8'hc0) begin err_cnt++; $display("FAIL sta_log_data got=%h exp=c0", bus.log_data); end
        vec_cnt++; if (bus.write_count !== 16'd1) begin err_cnt++; $display("FAIL sta_count got=%h exp=0001", bus.write_count); end
        pop_one();
        vec_cnt++; if (bus.log_valid !== 1'b0) begin err_cnt++; $display("FAIL sta_pop_valid got=%b exp=0", bus.log_valid); end
    endtask

    task automatic test_decode();
        cpu_read(16'hfffc);
        vec_cnt++; if (bus.rdata !== 8'h34) begin err_cnt++; $display("FAIL vec_lo got=%h exp=34", bus.rdata); end
        cpu_read(16'hfffd);
        vec_cnt++; if (bus.rdata !== 8'h12) begin err_cnt++; $display("FAIL vec_hi got=%h exp=12", bus.rdata); end
        cpu_read(16'hfffe);
        vec_cnt++; if (bus.rdata !== 8'hff) begin err_cnt++; $display("FAIL fill_fffe got=%h exp=ff", bus.rdata); end
        preload(16'h07ff, 8'h5a);
        cpu_read(16'h07ff);
        vec_cnt++; if (bus.rdata !== 8'h5a) begin err_cnt++; $display("FAIL ram_top got=%h exp=5a", bus.rdata); end
        cpu_read(16'h0800);
        vec_cnt++; if (bus.rdata !== 8'hff) begin err_cnt++; $display("FAIL ram_end got=%h exp=ff", bus.rdata); end
    endtask

    task automatic test_overflow();
        logic [7:0] rc;
        for (int i = 0; i < 9; i++) begin
            cpu_write(16'h0100 + 16'(i), 8'h10 + 8'(i), 1'b0, rc);
        end
        vec_cnt++; if (bus.log_overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_flag got=%b exp=1", bus.log_overflow); end
        vec_cnt++; if (bus.write_count !== 16'd10) begin err_cnt++; $display("FAIL ovf_count got=%h exp=000a", bus.write_count); end
        for (int i = 0; i < 8; i++) begin
            vec_cnt++; if (bus.log_addr !== 16'h0100 + 16'(i)) begin err_cnt++; $display("FAIL ovf_addr%0d got=%h exp=%h", i, bus.log_addr, 16'h0100 + 16'(i)); end
            vec_cnt++; if (bus.log_data !== 8'h10 + 8'(i)) begin err_cnt++; $display("FAIL ovf_data%0d got=%h exp=%h", i, bus.log_data, 8'h10 + 8'(i)); end
            pop_one();
        end
        vec_cnt++; if (bus.log_valid !== 1'b0) begin err_cnt++; $display("FAIL ovf_drained got=%b exp=0", bus.log_valid); end
        pop_one();
        vec_cnt++; if (bus.log_valid !== 1'b0) begin err_cnt++; $display("FAIL empty_pop_valid got=%b exp=0", bus.log_valid); end
        vec_cnt++; if ({bus.log_addr, bus.log_data} !== 24'd0) begin err_cnt++; $display("FAIL empty_head got=%h exp=000000", {bus.log_addr, bus.log_data}); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rc;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vec_cnt++; if (bus.log_overflow !== 1'b0) begin err_cnt++; $display("FAIL b2b_ovf_clr got=%b exp=0", bus.log_overflow); end
        for (int i = 0; i < 8; i++) begin
            cpu_write(16'h0200 + 16'(i), 8'h20 + 8'(i), 1'b0, rc);
        end
        vec_cnt++; if (bus.log_overflow !== 1'b0) begin err_cnt++; $display("FAIL b2b_full_ovf got=%b exp=0", bus.log_overflow); end
        cpu_write(16'h0300, 8'h77, 1'b1, rc);
        vec_cnt++; if (bus.log_overflow !== 1'b0) begin err_cnt++; $display("FAIL b2b_pushpop_ovf got=%b exp=0", bus.log_overflow); end
        vec_cnt++; if (bus.write_count !== 16'd9) begin err_cnt++; $display("FAIL b2b_count got=%h exp=0009", bus.write_count); end
        for (int i = 1; i < 9; i++) begin
            logic [15:0] ea;
            logic [7:0]  ed;
            ea = (i == 8) ? 16'h0300 : 16'h0200 + 16'(i);
            ed = (i == 8) ? 8'h77    : 8'h20 + 8'(i);
            vec_cnt++; if (bus.log_addr !== ea) begin err_cnt++; $display("FAIL b2b_addr%0d got=%h exp=%h", i, bus.log_addr, ea); end
            vec_cnt++; if (bus.log_data !== ed) begin err_cnt++; $display("FAIL b2b_data%0d got=%h exp=%h", i, bus.log_data, ed); end
            pop_one();
        end
        vec_cnt++; if (bus.log_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_drained got=%b exp=0", bus.log_valid); end
    endtask

    task automatic test_unmapped();
        logic [7:0] rc;
        cpu_write(16'h4400, 8'h5c, 1'b0, rc);
        vec_cnt++; if (bus.log_addr !== 16'h4400) begin err_cnt++; $display("FAIL unm_log_addr got=%h exp=4400", bus.log_addr); end
        vec_cnt++; if (bus.log_data !== 8'h5c) begin err_cnt++; $display("FAIL unm_log_data got=%h exp=5c", bus.log_data); end
        vec_cnt++; if (bus.write_count !== 16'd10) begin err_cnt++; $display("FAIL unm_count got=%h exp=000a", bus.write_count); end
        cpu_read(16'h4400);
        vec_cnt++; if (bus.rdata !== 8'hff) begin err_cnt++; $display("FAIL unm_read got=%h exp=ff", bus.rdata); end
        cpu_read(16'h0400);
        vec_cnt++; if (bus.rdata !== 8'h11) begin err_cnt++; $display("FAIL no_mirror got=%h exp=11", bus.rdata); end
        pop_one();
    endtask

    task automatic test_preload_priority();
        bus.addr  = 16'h0050;
        bus.wdata = 8'haa;
        bus.rw    = 1'b0;
        bus.clk2  = 1'b1;
        tick();
        bus.clk2    = 1'b0;
        bus.ld_en   = 1'b1;
        bus.ld_addr = 16'h0050;
        bus.ld_data = 8'hbb;
        tick();
        bus.ld_en = 1'b0;
        bus.rw    = 1'b1;
        tick();
        $display("txn write addr=0050 data=aa with preload data=bb");
        cpu_read(16'h0050);
        vec_cnt++; if (bus.rdata !== 8'hbb) begin err_cnt++; $display("FAIL prio_ram got=%h exp=bb", bus.rdata); end
        vec_cnt++; if ({bus.log_addr, bus.log_data} !== 24'h0050aa) begin err_cnt++; $display("FAIL prio_log got=%h exp=0050aa", {bus.log_addr, bus.log_data}); end
        vec_cnt++; if (bus.write_count !== 16'd11) begin err_cnt++; $display("FAIL prio_count got=%h exp=000b", bus.write_count); end
        preload(16'h0850, 8'h99);
        cpu_read(16'h0050);
        vec_cnt++; if (bus.rdata !== 8'hbb) begin err_cnt++; $display("FAIL ld_oor got=%h exp=bb", bus.rdata); end
        vec_cnt++; if (bus.write_count !== 16'd11) begin err_cnt++; $display("FAIL ld_not_counted got=%h exp=000b", bus.write_count); end
    endtask

    task automatic test_reset_mid_phi2();
        preload(16'h0061, 8'h3c);
        bus.addr  = 16'h0061;
        bus.wdata = 8'hee;
        bus.rw    = 1'b0;
        bus.clk2  = 1'b1;
        tick();
        bus.clk2 = 1'b0;
        reset    = 1'b1;
        tick();
        reset  = 1'b0;
        bus.rw = 1'b1;
        tick();
        $display("txn write addr=0061 data=ee under reset");
        vec_cnt++; if (bus.log_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_valid got=%b exp=0", bus.log_valid); end
        vec_cnt++; if (bus.write_count !== 16'd0) begin err_cnt++; $display("FAIL rmid_count got=%h exp=0000", bus.write_count); end
        cpu_read(16'h0061);
        vec_cnt++; if (bus.rdata !== 8'h3c) begin err_cnt++; $display("FAIL rmid_ram got=%h exp=3c", bus.rdata); end
        cpu_read(16'h0099);
        vec_cnt++; if (bus.rdata !== 8'hc0) begin err_cnt++; $display("FAIL rmid_ram99 got=%h exp=c0", bus.rdata); end
    endtask

    initial begin
        vec_cnt     = 0;
        err_cnt     = 0;
        reset       = 1'b1;
        bus.addr    = 16'h0000;
        bus.wdata   = 8'h00;
        bus.rw      = 1'b1;
        bus.clk2    = 1'b0;
        bus.ld_en   = 1'b0;
        bus.ld_addr = 16'h0000;
        bus.ld_data = 8'h00;
        bus.log_pop = 1'b0;

        test_reset();
        test_sta();
        test_decode();
        test_overflow();
        test_back_to_back();
        test_unmapped();
        test_preload_priority();
        test_reset_mid_phi2();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
